// File: rtl/byte_word_packer.sv
// Packs a valid/ready byte stream into 32-bit words for the word FIFO write port, never writing while full.
// Define PACKER_FLUSH_EN to let in_last close a partial word early, padding unused lanes with PAD_BYTE.
module byte_word_packer #(
   parameter bit         BIG_ENDIAN = 1'b0,
   parameter logic [7:0] PAD_BYTE   = 8'h00,
   parameter int         CNT_W      = 16
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             in_valid,
   input  logic [7:0]       in_data,
   input  logic             in_last,
   output logic             in_ready,
   input  logic             fifo_full,
   output logic             fifo_wr,
   output logic [31:0]      fifo_data,
   output logic [CNT_W-1:0] word_count
);

   typedef enum logic {
      FILL = 1'b0,
      HOLD = 1'b1
   } state_t;

   state_t      state;
   state_t      state_next;
   logic [1:0]  byte_idx;
   logic [1:0]  lane;
   logic [31:0] pack_word;
   logic [31:0] hold_word;
   logic [31:0] merged_word;
   logic        accept;
   logic        word_done;

`ifndef PACKER_FLUSH_EN
   logic unused_last;
   assign unused_last = in_last;
`endif

   // The word being assembled with the current byte dropped into its lane.
   always_comb begin
      lane        = BIG_ENDIAN ? (2'd3 - byte_idx) : byte_idx;
      merged_word = pack_word;
      merged_word[{lane, 3'b000} +: 8] = in_data;
   end

   always_comb begin
      in_ready = (state == FILL) && reset_n;
      fifo_wr  = (state == HOLD) && !fifo_full && reset_n;
      accept   = in_valid && in_ready;
`ifdef PACKER_FLUSH_EN
      word_done = accept && ((byte_idx == 2'd3) || in_last);
`else
      word_done = accept && (byte_idx == 2'd3);
`endif
   end

   always_comb begin
      state_next = state;
      case (state)
         FILL: if (word_done) state_next = HOLD;
         HOLD: if (fifo_wr)   state_next = FILL;
         default:             state_next = FILL;
      endcase
   end

   // The finished word is copied out on completion, so the packing lanes can be
   // refilled with pad right away while the FIFO side still sees a stable word.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state      <= FILL;
         byte_idx   <= 2'd0;
         pack_word  <= {4{PAD_BYTE}};
         hold_word  <= 32'h0;
         word_count <= '0;
      end else begin
         state <= state_next;
         if (word_done) begin
            byte_idx  <= 2'd0;
            hold_word <= merged_word;
            pack_word <= {4{PAD_BYTE}};
         end else if (accept) begin
            byte_idx  <= byte_idx + 2'd1;
            pack_word <= merged_word;
         end
         if (fifo_wr) begin
            word_count <= word_count + 1'b1;
         end
      end
   end

   assign fifo_data = hold_word;

endmodule

// File: tb/tb_byte_word_packer.sv
// Directed bench driving a little-endian (CNT_W=2) and a big-endian packer with the same byte stream.
// Expected words and counts are written out by hand for each step.
module tb_byte_word_packer;

   logic        clock = 1'b0;
   logic        reset_n;
   logic        in_valid;
   logic [7:0]  in_data;
   logic        in_last;
   logic        fifo_full;

   logic        ready_le, wr_le, ready_be, wr_be;
   logic [31:0] data_le, data_be;
   logic [1:0]  cnt_le;
   logic [15:0] cnt_be;

   int assert_count = 0;
   int fail_count   = 0;

   always #5 clock = ~clock;

   byte_word_packer #(.BIG_ENDIAN(1'b0), .PAD_BYTE(8'h00), .CNT_W(2)) dut_le (
      .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_data(in_data),
      .in_last(in_last), .in_ready(ready_le), .fifo_full(fifo_full),
      .fifo_wr(wr_le), .fifo_data(data_le), .word_count(cnt_le)
   );

   byte_word_packer #(.BIG_ENDIAN(1'b1), .PAD_BYTE(8'h00), .CNT_W(16)) dut_be (
      .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_data(in_data),
      .in_last(in_last), .in_ready(ready_be), .fifo_full(fifo_full),
      .fifo_wr(wr_be), .fifo_data(data_be), .word_count(cnt_be)
   );

   // Inputs change just after a rising edge; outputs are then sampled mid-cycle.
   task automatic applyStimulus(input logic v, input logic [7:0] d, input logic l, input logic f);
      @(posedge clock);
      #1;
      in_valid  = v;
      in_data   = d;
      in_last   = l;
      fifo_full = f;
      #1;
   endtask

   task automatic sendWord(input logic [7:0] b0, b1, b2, b3);
      applyStimulus(1'b1, b0, 1'b0, 1'b0);
      applyStimulus(1'b1, b1, 1'b0, 1'b0);
      applyStimulus(1'b1, b2, 1'b0, 1'b0);
      applyStimulus(1'b1, b3, 1'b0, 1'b0);
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      assert_count++;
      assert (observed === expected) else begin
         fail_count++;
         $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
      end
   endtask

   task automatic checkState(input string tag, input logic wr, input logic rdy,
                             input logic [31:0] exp_le, input logic [31:0] exp_be,
                             input logic [31:0] exp_cnt_le, input logic [31:0] exp_cnt_be);
      checkOutput({tag, ".wr_le"},    {31'h0, wr_le},    {31'h0, wr});
      checkOutput({tag, ".wr_be"},    {31'h0, wr_be},    {31'h0, wr});
      checkOutput({tag, ".ready_le"}, {31'h0, ready_le}, {31'h0, rdy});
      checkOutput({tag, ".ready_be"}, {31'h0, ready_be}, {31'h0, rdy});
      checkOutput({tag, ".data_le"},  data_le,           exp_le);
      checkOutput({tag, ".data_be"},  data_be,           exp_be);
      checkOutput({tag, ".cnt_le"},   {30'h0, cnt_le},   exp_cnt_le);
      checkOutput({tag, ".cnt_be"},   {16'h0, cnt_be},   exp_cnt_be);
   endtask

   initial begin
      logic [7:0] bytes [4];

      reset_n   = 1'b0;
      in_valid  = 1'b0;
      in_data   = 8'h00;
      in_last   = 1'b0;
      fifo_full = 1'b0;
      $display("[TB] start");

      applyStimulus(1'b1, 8'h99, 1'b0, 1'b0);
      applyStimulus(1'b1, 8'h99, 1'b0, 1'b0);
      checkState("reset", 1'b0, 1'b0, 32'h0, 32'h0, 0, 0);
      @(posedge clock);
      #1;
      reset_n  = 1'b1;
      in_valid = 1'b0;
      #1;
      checkState("release", 1'b0, 1'b1, 32'h0, 32'h0, 0, 0);

      // T1/T2: basic packing in both lane orders
      sendWord(8'h11, 8'h22, 8'h33, 8'h44);
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
      checkState("t1_hold", 1'b1, 1'b0, 32'h44332211, 32'h11223344, 0, 0);
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
      checkState("t1_done", 1'b0, 1'b1, 32'h44332211, 32'h11223344, 1, 1);

      // T3: FIFO full for three cycles, with in_valid held high to prove no byte is taken
      sendWord(8'h55, 8'h66, 8'h77, 8'h88);
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b1, 8'hFF, 1'b0, 1'b1);
         checkState("t3_full", 1'b0, 1'b0, 32'h88776655, 32'h55667788, 1, 1);
      end
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
      checkState("t3_wr", 1'b1, 1'b0, 32'h88776655, 32'h55667788, 1, 1);
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
      checkState("t3_done", 1'b0, 1'b1, 32'h88776655, 32'h55667788, 2, 2);

      // T4: in_last on the second byte
      applyStimulus(1'b1, 8'hAA, 1'b0, 1'b0);
      applyStimulus(1'b1, 8'hBB, 1'b1, 1'b0);
`ifdef PACKER_FLUSH_EN
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
      checkState("t4_flush", 1'b1, 1'b0, 32'h0000BBAA, 32'hAABB0000, 2, 2);
`else
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
      checkState("t4_wait", 1'b0, 1'b1, 32'h88776655, 32'h55667788, 2, 2);
      applyStimulus(1'b1, 8'hCC, 1'b0, 1'b0);
      applyStimulus(1'b1, 8'hDD, 1'b0, 1'b0);
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
      checkState("t4_full_word", 1'b1, 1'b0, 32'hDDCCBBAA, 32'hAABBCCDD, 2, 2);
`endif
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
      checkOutput("t4_cnt_le", {30'h0, cnt_le}, 32'd3);
      checkOutput("t4_cnt_be", {16'h0, cnt_be}, 32'd3);

      // T5: reset while a word is held against a full FIFO
      sendWord(8'h01, 8'h02, 8'h03, 8'h04);
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
      checkState("t5_hold", 1'b0, 1'b0, 32'h04030201, 32'h01020304, 3, 3);
      reset_n = 1'b0;
      #1;
      checkState("t5_in_reset", 1'b0, 1'b0, 32'h04030201, 32'h01020304, 3, 3);
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
      checkState("t5_cleared", 1'b0, 1'b0, 32'h0, 32'h0, 0, 0);
      @(posedge clock);
      #1;
      reset_n = 1'b1;
      #1;
      checkState("t5_release", 1'b0, 1'b1, 32'h0, 32'h0, 0, 0);
      sendWord(8'hA1, 8'hB2, 8'hC3, 8'hD4);
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
      checkState("t5_repack", 1'b1, 1'b0, 32'hD4C3B2A1, 32'hA1B2C3D4, 0, 0);
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
      checkState("t5_done", 1'b0, 1'b1, 32'hD4C3B2A1, 32'hA1B2C3D4, 1, 1);

      // T6: four more words; the 2-bit counter runs 2,3,0,1
      for (int i = 0; i < 4; i++) begin
         for (int j = 0; j < 4; j++) begin
            bytes[j] = 8'(16 * (i + 2) + j + 1);
         end
         sendWord(bytes[0], bytes[1], bytes[2], bytes[3]);
         applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
         checkOutput("t6_wr_le", {31'h0, wr_le}, 32'd1);
         checkOutput("t6_data_le", data_le, {bytes[3], bytes[2], bytes[1], bytes[0]});
         checkOutput("t6_data_be", data_be, {bytes[0], bytes[1], bytes[2], bytes[3]});
         applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
         checkOutput("t6_cnt_le", {30'h0, cnt_le}, 32'((2 + i) % 4));
         checkOutput("t6_cnt_be", {16'h0, cnt_be}, 32'(2 + i));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
      $finish;
   end

endmodule
